// File: rtl/vectored_int_sched_if.sv
// Signal bundle between the accelerator done flags, the scheduler and the CPU
// interrupt port.
interface vectored_int_sched_if;
    logic        done1;
    logic        done2;
    logic        done3;
    logic        done4;
    logic [3:0]  int_mask;
    logic        int_ack;
    logic        int_eoi;
    logic        int_req;
    logic [31:0] int_addr;
    logic [1:0]  cur_id;
    logic        in_service;
    logic [3:0]  pending;

    modport master (
        output done1, done2, done3, done4, int_mask, int_ack, int_eoi,
        input  int_req, int_addr, cur_id, in_service, pending
    );

    modport slave (
        input  done1, done2, done3, done4, int_mask, int_ack, int_eoi,
        output int_req, int_addr, cur_id, in_service, pending
    );
endinterface

// File: rtl/vectored_int_sched.sv
// Round-robin vectored interrupt scheduler: latches done rising edges into
// pending bits and hands one source at a time to the CPU via ack/EOI.
module vectored_int_sched #(
    parameter logic [31:0] VEC_BASE   = 32'h0000_0004,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0001
) (
    input logic                  clk,
    input logic                  rst_n,
    vectored_int_sched_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  done_q, done_d;
    logic [3:0]  pending_q, pending_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  cur_id_q, cur_id_d;
    logic        int_req_q, int_req_d;
    logic        in_service_q, in_service_d;
    logic [31:0] int_addr_q, int_addr_d;

    logic [3:0]  done_now;
    logic [3:0]  rise;
    logic [3:0]  clr;
    logic [2:0]  pick;

    function automatic logic [31:0] vec_addr(input logic [1:0] id);
        return VEC_BASE + ({30'd0, id} * VEC_STRIDE);
    endfunction

    // Returns {found, index}; search starts at ptr and wraps modulo 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] elig, input logic [1:0] ptr);
        logic       found;
        logic [1:0] idx;
        logic [1:0] win;
        found = 1'b0;
        win   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    assign done_now = {bus.done4, bus.done3, bus.done2, bus.done1};
    assign rise     = done_now & ~done_q;
    assign pick     = rr_pick(pending_q & ~bus.int_mask, ptr_q);

    always_comb begin
        state_d      = state_q;
        done_d       = done_now;
        ptr_d        = ptr_q;
        cur_id_d     = cur_id_q;
        int_req_d    = int_req_q;
        in_service_d = in_service_q;
        int_addr_d   = int_addr_q;
        clr          = 4'b0000;

        case (state_q)
            IDLE: begin
                if (pick[2]) begin
                    cur_id_d   = pick[1:0];
                    int_addr_d = vec_addr(pick[1:0]);
                    int_req_d  = 1'b1;
                    state_d    = REQ;
                end
            end
            REQ: begin
                // Ack wins over a simultaneous EOI; EOI is only meaningful in SERVICE.
                if (bus.int_ack) begin
                    clr          = 4'b0001 << cur_id_q;
                    int_req_d    = 1'b0;
                    in_service_d = 1'b1;
                    state_d      = SERVICE;
                end
            end
            SERVICE: begin
                if (bus.int_eoi) begin
                    ptr_d        = cur_id_q + 2'd1;
                    in_service_d = 1'b0;
                    int_addr_d   = 32'h0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d      = IDLE;
                int_req_d    = 1'b0;
                in_service_d = 1'b0;
                int_addr_d   = 32'h0;
            end
        endcase

        // A new edge on the bit being cleared keeps it pending.
        pending_d = (pending_q & ~clr) | rise;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            done_q       <= 4'b0000;
            pending_q    <= 4'b0000;
            ptr_q        <= 2'd0;
            cur_id_q     <= 2'd0;
            int_req_q    <= 1'b0;
            in_service_q <= 1'b0;
            int_addr_q   <= 32'h0;
        end else begin
            state_q      <= state_d;
            done_q       <= done_d;
            pending_q    <= pending_d;
            ptr_q        <= ptr_d;
            cur_id_q     <= cur_id_d;
            int_req_q    <= int_req_d;
            in_service_q <= in_service_d;
            int_addr_q   <= int_addr_d;
        end
    end

    assign bus.int_req    = int_req_q;
    assign bus.int_addr   = int_addr_q;
    assign bus.cur_id     = cur_id_q;
    assign bus.in_service = in_service_q;
    assign bus.pending    = pending_q;

endmodule

// File: tb/tb_vectored_int_sched.sv
// Directed bench for vectored_int_sched with a queue of expected service ids.
module tb_vectored_int_sched;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [1:0] exp_q[$];

    vectored_int_sched_if bus();

    vectored_int_sched #(
        .VEC_BASE   (32'h0000_0004),
        .VEC_STRIDE (32'h0000_0001)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_done(input logic [3:0] v);
        bus.done1 = v[0];
        bus.done2 = v[1];
        bus.done3 = v[2];
        bus.done4 = v[3];
    endtask

    // One-cycle high pulse on the selected done lines.
    task automatic pulse(input logic [3:0] v);
        set_done(v);
        tick();
        set_done(4'b0000);
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (bus.int_req !== 1'b1 && n < 12) begin
            tick();
            n++;
        end
        chk({tag, "_req_seen"}, {31'd0, bus.int_req}, 32'd1);
    endtask

    // Wait for the next request, compare it to the scoreboard head, then ack and EOI.
    task automatic serve(input string tag);
        logic [1:0] e;
        wait_req(tag);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
            e = 2'd0;
        end else begin
            e = exp_q.pop_front();
        end
        chk({tag, "_id"}, {30'd0, bus.cur_id}, {30'd0, e});
        chk({tag, "_addr"}, bus.int_addr, 32'h4 + {30'd0, e});
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        chk({tag, "_svc"}, {30'd0, bus.in_service, bus.int_req}, 32'b10);
        chk({tag, "_svc_id"}, {30'd0, bus.cur_id}, {30'd0, e});
        bus.int_eoi = 1'b1;
        tick();
        bus.int_eoi = 1'b0;
        chk({tag, "_idle"}, {bus.int_addr[29:0], bus.in_service, bus.int_req}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        set_done(4'b0000);
        bus.int_mask = 4'b0000;
        bus.int_ack  = 1'b0;
        bus.int_eoi  = 1'b0;

        do_reset();
        chk("rst_req", {31'd0, bus.int_req}, 32'd0);
        chk("rst_addr", bus.int_addr, 32'h0);
        chk("rst_id", {30'd0, bus.cur_id}, 32'd0);
        chk("rst_pend", {28'd0, bus.pending}, 32'd0);
        chk("rst_svc", {31'd0, bus.in_service}, 32'd0);

        // Single source, exact two-cycle latency.
        set_done(4'b0010);
        tick();
        chk("lat_pend", {28'd0, bus.pending}, 32'b0010);
        chk("lat_req0", {31'd0, bus.int_req}, 32'd0);
        set_done(4'b0000);
        tick();
        chk("lat_req1", {31'd0, bus.int_req}, 32'd1);
        exp_q.push_back(2'd1);
        bus.int_ack = 1'b1;
        chk("d2_addr", bus.int_addr, 32'h5);
        tick();
        bus.int_ack = 1'b0;
        exp_q.delete(0);
        chk("d2_pend_clr", {28'd0, bus.pending}, 32'd0);
        chk("d2_svc", {31'd0, bus.in_service}, 32'd1);
        bus.int_eoi = 1'b1;
        tick();
        bus.int_eoi = 1'b0;
        chk("d2_idle_addr", bus.int_addr, 32'h0);

        // All four at once from a fresh pointer.
        do_reset();
        pulse(4'b1111);
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd3);
        serve("all0");
        serve("all1");
        serve("all2");
        serve("all3");

        // After id 2 the pointer sits at 3, so id 3 beats id 0.
        pulse(4'b0100);
        exp_q.push_back(2'd2);
        serve("rr2");
        pulse(4'b1001);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd0);
        serve("rr3");
        serve("rr0");

        // Masked source is held, then released.
        bus.int_mask = 4'b0001;
        pulse(4'b0001);
        tick();
        tick();
        chk("mask_req", {31'd0, bus.int_req}, 32'd0);
        chk("mask_pend", {28'd0, bus.pending}, 32'b0001);
        bus.int_mask = 4'b0000;
        exp_q.push_back(2'd0);
        serve("unmask");

        // Re-trigger in the ack cycle; stray ack in SERVICE; ack+EOI in REQ.
        pulse(4'b0100);
        wait_req("re");
        chk("re_id", {30'd0, bus.cur_id}, 32'd2);
        bus.int_ack = 1'b1;
        set_done(4'b0100);
        tick();
        bus.int_ack = 1'b0;
        set_done(4'b0000);
        chk("re_pend_keep", {28'd0, bus.pending}, 32'b0100);
        chk("re_svc", {31'd0, bus.in_service}, 32'd1);
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        chk("stray_ack_svc", {31'd0, bus.in_service}, 32'd1);
        chk("stray_ack_pend", {28'd0, bus.pending}, 32'b0100);
        bus.int_eoi = 1'b1;
        tick();
        bus.int_eoi = 1'b0;
        chk("re_idle", {31'd0, bus.int_req}, 32'd0);
        wait_req("re2");
        chk("re2_id", {30'd0, bus.cur_id}, 32'd2);
        bus.int_ack = 1'b1;
        bus.int_eoi = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        bus.int_eoi = 1'b0;
        chk("ackeoi_svc", {30'd0, bus.in_service, bus.int_req}, 32'b10);
        bus.int_eoi = 1'b1;
        tick();
        bus.int_eoi = 1'b0;
        chk("re2_done", {30'd0, bus.in_service, bus.int_req}, 32'd0);
        bus.int_eoi = 1'b1;
        tick();
        bus.int_eoi = 1'b0;
        tick();
        chk("stray_eoi", {bus.int_addr[27:0], bus.pending}, 32'd0);
        chk("stray_eoi_req", {30'd0, bus.in_service, bus.int_req}, 32'd0);

        // Reset while in SERVICE with two sources pending.
        pulse(4'b1010);
        wait_req("rs");
        chk("rs_id", {30'd0, bus.cur_id}, 32'd3);
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
        pulse(4'b1000);
        chk("rs_pend", {28'd0, bus.pending}, 32'b1010);
        chk("rs_svc", {31'd0, bus.in_service}, 32'd1);
        rst_n = 1'b0;
        tick();
        chk("rs_out", {bus.int_addr[27:0], bus.pending}, 32'd0);
        chk("rs_ctl", {29'd0, bus.cur_id, bus.in_service | bus.int_req}, 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk("rs_after", {27'd0, bus.int_req, bus.pending}, 32'd0);

        chk("sb_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
